multi_timer_irq: RTL and testbench

//  Parametrised successor of the single-limit timer: NUM_CH independent

---
 rtl/multi_timer_irq.sv | 117 +++++++++++
 tb/tb_multi_timer_irq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer_irq.sv
// NUM_CH interval timers sharing one prescaler, each with limit, enable, periodic/one-shot
// mode and a sticky pending bit; drives a masked interrupt and the lowest pending channel id.
module multi_timer_irq #(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_WIDTH   = 32,
    parameter  int PRESC_WIDTH = 8,
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PRESC_WIDTH-1:0] prescale,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [CNT_WIDTH-1:0]   cfg_limit,
    input  logic                   cfg_mode,
    input  logic                   cfg_en,
    input  logic [NUM_CH-1:0]      irq_mask,
    input  logic [NUM_CH-1:0]      irq_ack,
    output logic [NUM_CH-1:0]      irq_pending,
    output logic                   timer_int,
    output logic [CH_W-1:0]        irq_id,
    input  logic [CH_W-1:0]        cnt_sel,
    output logic [CNT_WIDTH-1:0]   cnt_val
);

    logic [PRESC_WIDTH-1:0] r_presc_cnt;
    logic [CNT_WIDTH-1:0]   r_limit [NUM_CH];
    logic [CNT_WIDTH-1:0]   r_cnt   [NUM_CH];
    logic [NUM_CH-1:0]      r_en;
    logic [NUM_CH-1:0]      r_mode;
    logic [NUM_CH-1:0]      r_pending;

    logic                   w_tick;
    logic [NUM_CH-1:0]      w_cfg_hit;
    logic [NUM_CH-1:0]      w_advance;
    logic [NUM_CH-1:0]      w_expire;
    logic [NUM_CH-1:0]      w_active;

    // >= rather than == so that lowering prescale mid-count ticks at once.
    assign w_tick = (r_presc_cnt >= prescale);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        w_cfg_hit = '0;
        w_advance = '0;
        w_expire  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // An out-of-range cfg_ch matches no channel, so the write is dropped.
            w_cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
            w_advance[i] = r_en[i] && w_tick && (r_limit[i] != '0);
            w_expire[i]  = w_advance[i] && (r_cnt[i] == r_limit[i] - CNT_WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_cnt <= '0;
            r_en        <= '0;
            r_mode      <= '0;
            r_pending   <= '0;
            // NOTE: limit/counter arrays are ordinary flops and are cleared, so no stale
            // configuration can fire after reset.
            for (int i = 0; i < NUM_CH; i++) begin
                r_limit[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep every channel working from pre-edge values.
            r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_WIDTH'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cfg_hit[i]) begin
                    r_limit[i]   <= cfg_limit;
                    r_mode[i]    <= cfg_mode;
                    r_en[i]      <= cfg_en;
                    r_cnt[i]     <= '0;
                    r_pending[i] <= 1'b0;
                end else begin
                    if (w_expire[i]) begin
                        r_cnt[i]     <= '0;
                        r_pending[i] <= 1'b1;
                        if (r_mode[i]) begin
                            r_en[i] <= 1'b0;
                        end
                    end else begin
                        if (w_advance[i]) begin
                            r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                        end
                        // An ack on the expiry edge loses to the new event.
                        if (irq_ack[i]) begin
                            r_pending[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign w_active    = r_pending & irq_mask;
    assign irq_pending = r_pending;
    assign timer_int   = |w_active;

    always_comb begin
        irq_id  = '0;
        cnt_val = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                irq_id = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_sel == CH_W'(i)) begin
                cnt_val = r_cnt[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_timer_irq.sv
// Randomised and scripted bench for multi_timer_irq against a tick-counting reference model.
module tb_multi_timer_irq;

    localparam int NUM_CH      = 4;
    localparam int CNT_WIDTH   = 32;
    localparam int PRESC_WIDTH = 8;
    localparam int CH_W        = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [PRESC_WIDTH-1:0] prescale;
    logic                   cfg_we;
    logic [CH_W-1:0]        cfg_ch;
    logic [CNT_WIDTH-1:0]   cfg_limit;
    logic                   cfg_mode;
    logic                   cfg_en;
    logic [NUM_CH-1:0]      irq_mask;
    logic [NUM_CH-1:0]      irq_ack;
    logic [NUM_CH-1:0]      irq_pending;
    logic                   timer_int;
    logic [CH_W-1:0]        irq_id;
    logic [CH_W-1:0]        cnt_sel;
    logic [CNT_WIDTH-1:0]   cnt_val;

    multi_timer_irq #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .PRESC_WIDTH(PRESC_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .prescale(prescale),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_limit(cfg_limit),
        .cfg_mode(cfg_mode), .cfg_en(cfg_en),
        .irq_mask(irq_mask), .irq_ack(irq_ack),
        .irq_pending(irq_pending), .timer_int(timer_int), .irq_id(irq_id),
        .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: clocks since last tick, ticks elapsed in the current period.
    int          m_presc;
    longint      m_limit [NUM_CH];
    longint      m_ticks [NUM_CH];
    bit          m_run   [NUM_CH];
    bit          m_oneshot [NUM_CH];
    bit [NUM_CH-1:0] m_pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic bound_expired(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", tag, $time);
    endtask

    function automatic bit tick_now();
        return m_presc >= int'(prescale);
    endfunction

    function automatic bit expires_next(input int ch);
        return m_run[ch] && tick_now() && m_limit[ch] != 0 && m_ticks[ch] + 1 == m_limit[ch];
    endfunction

    task automatic model_update();
        bit tick;
        bit fired;
        if (reset) begin
            m_presc = 0;
            m_pend  = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_limit[c] = 0; m_ticks[c] = 0; m_run[c] = 0; m_oneshot[c] = 0;
            end
            return;
        end
        tick    = tick_now();
        m_presc = tick ? 0 : m_presc + 1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_we && int'(cfg_ch) == c) begin
                m_limit[c]   = longint'(cfg_limit);
                m_oneshot[c] = cfg_mode;
                m_run[c]     = cfg_en;
                m_ticks[c]   = 0;
                m_pend[c]    = 1'b0;
            end else begin
                fired = 1'b0;
                if (m_run[c] && tick && m_limit[c] != 0) begin
                    m_ticks[c]++;
                    if (m_ticks[c] == m_limit[c]) begin
                        fired      = 1'b1;
                        m_ticks[c] = 0;
                        m_pend[c]  = 1'b1;
                        if (m_oneshot[c]) m_run[c] = 1'b0;
                    end
                end
                if (irq_ack[c] && !fired) m_pend[c] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [CH_W-1:0] exp_id;
        logic [NUM_CH-1:0] act;
        act    = m_pend & irq_mask;
        exp_id = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) if (act[c]) exp_id = CH_W'(c);
        check("pending", 64'(irq_pending), 64'(m_pend));
        check("timer_int", 64'(timer_int), 64'(act != 0));
        check("irq_id", 64'(irq_id), 64'(exp_id));
        check("cnt_val", 64'(cnt_val), 64'(m_ticks[cnt_sel]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        cfg_we  = 1'b0;
        irq_ack = '0;
        reset   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic cfg_write(input int ch, input longint lim, input bit mode, input bit en);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_limit = CNT_WIDTH'(lim);
        cfg_mode  = mode;
        cfg_en    = en;
    endtask

    // Leaves the bench one clock before the edge on which channel ch expires.
    task automatic wait_expiry(input int ch, input int budget, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (expires_next(ch)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) bound_expired(tag);
    endtask

    task automatic quiesce();
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_write(c, 0, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        reset = 1'b1; prescale = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_limit = '0;
        cfg_mode = 1'b0; cfg_en = 1'b0; irq_mask = '0; irq_ack = '0; cnt_sel = '0;
        step();
        check("rst_pending", 64'(irq_pending), 64'(0));
        check("rst_int", 64'(timer_int), 64'(0));
        check("rst_cnt", 64'(cnt_val), 64'(0));

        // Periodic ch0, limit 100, no prescale.
        irq_mask = 4'b0001;
        cfg_write(0, 100, 1'b0, 1'b1);
        step();
        for (int p = 0; p < 2; p++) begin
            wait_expiry(0, 200, "t1_wait");
            step();
            check("t1_int_set", 64'(timer_int), 64'(1));
            irq_ack = 4'b0001;
            step();
            check("t1_int_clr", 64'(timer_int), 64'(0));
        end
        quiesce();

        // One-shot ch1, limit 5, prescale 3.
        prescale = 8'd3;
        irq_mask = 4'b0010;
        cnt_sel  = 2'd1;
        cfg_write(1, 5, 1'b1, 1'b1);
        step();
        run(25);
        check("t2_pend", 64'(irq_pending[1]), 64'(1));
        check("t2_cnt", 64'(cnt_val), 64'(0));
        irq_ack = 4'b0010;
        step();
        run(200);
        check("t2_no_refire", 64'(irq_pending[1]), 64'(0));

        // Two channels expiring on the same edge.
        prescale = 8'd0;
        irq_mask = 4'b0101;
        cfg_write(0, 8, 1'b1, 1'b1);
        step();
        cfg_write(2, 7, 1'b1, 1'b1);
        step();
        run(7);
        check("t3_both", 64'(irq_pending), 64'(4'b0101));
        check("t3_id0", 64'(irq_id), 64'(0));
        irq_ack = 4'b0001;
        step();
        check("t3_id2", 64'(irq_id), 64'(2));
        irq_ack = 4'b0100;
        step();
        check("t3_int0", 64'(timer_int), 64'(0));

        // Ack coincident with an expiry edge.
        irq_mask = 4'b0001;
        cfg_write(0, 9, 1'b0, 1'b1);
        step();
        wait_expiry(0, 50, "t4_wait");
        irq_ack = 4'b0001;
        step();
        check("t4_pend_kept", 64'(irq_pending[0]), 64'(1));
        quiesce();

        // Config write on the expiry edge of ch3, then limit 0.
        irq_mask = 4'b1000;
        cnt_sel  = 2'd3;
        cfg_write(3, 6, 1'b0, 1'b1);
        step();
        wait_expiry(3, 50, "t5_wait");
        cfg_write(3, 6, 1'b0, 1'b1);
        step();
        check("t5_pend_clr", 64'(irq_pending[3]), 64'(0));
        check("t5_cnt_restart", 64'(cnt_val), 64'(0));
        step();
        check("t5_cnt_one", 64'(cnt_val), 64'(1));
        cfg_write(3, 0, 1'b0, 1'b1);
        step();
        run(1000);
        check("t5_never", 64'(irq_pending[3]), 64'(0));
        check("t5_cnt_zero", 64'(cnt_val), 64'(0));

        // Reset in the middle of a count.
        irq_mask = 4'b1111;
        cnt_sel  = 2'd0;
        cfg_write(0, 100, 1'b0, 1'b1);
        step();
        run(50);
        check("t6_cnt50", 64'(cnt_val), 64'(50));
        reset = 1'b1;
        step();
        check("t6_rst_pend", 64'(irq_pending), 64'(0));
        check("t6_rst_cnt", 64'(cnt_val), 64'(0));
        run(300);
        check("t6_quiet", 64'(irq_pending), 64'(0));

        // Randomised traffic.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(63) == 0) prescale = PRESC_WIDTH'($urandom_range(3));
            if ($urandom_range(31) == 0) irq_mask = NUM_CH'($urandom);
            if ($urandom_range(11) == 0) begin
                cfg_write(int'($urandom_range(NUM_CH - 1)), longint'($urandom_range(12)),
                          1'($urandom), ($urandom_range(7) != 0));
            end
            for (int c = 0; c < NUM_CH; c++) irq_ack[c] = ($urandom_range(9) == 0);
            cnt_sel = CH_W'($urandom);
            if ($urandom_range(799) == 0) reset = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
